// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DMEM_DEPTH = 51;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve_guard.sv
// Host starvation guard: counts consecutive burst cycles in which the CPU
// blocked the host and raises force_slot once MAX_WAIT is reached.
module dmem_arb_starve_guard #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic cpu_req,
  input  logic host_slot,
  output logic force_slot
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  assign force_slot = busy && (cnt == CW'(MAX_WAIT));

  // Blocked-cycle counter; any host slot or leaving the burst clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!busy || host_slot) begin
      cnt <= '0;
    end else if (cpu_req) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a burst-capable host.
// CPU has combinational priority; host bursts use free cycles.
// Optional macro DMEM_ARB_FAIRNESS_EN: forced host slot after MAX_WAIT
// blocked cycles (CPU stalled for that cycle).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH    = DMEM_DEPTH,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CpuReq,
  input  logic             CpuWe,
  input  logic [31:0]      CpuAddr,
  input  logic [31:0]      CpuWData,
  output logic [31:0]      CpuRData,
  output logic             CpuStall,
  input  logic             HostReq,
  input  logic             HostWe,
  input  logic [31:0]      HostAddr,
  input  logic [LEN_W-1:0] HostLen,
  input  logic [31:0]      HostWData,
  output logic             HostWReady,
  output logic [31:0]      HostRData,
  output logic             HostRValid,
  output logic             HostBusy,
  output logic             HostDone,
  output logic             HostErr,
  output logic             MemWe,
  output logic [31:0]      MemAddr,
  output logic [31:0]      MemWData,
  input  logic [31:0]      MemRData
);

  arb_state_e       state;
  logic [31:0]      base;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] beat;
  logic             dir;

  logic             force_slot;
  logic             host_slot;
  logic             host_oor;
  logic             last_beat;
  logic [31:0]      host_addr;

  assign host_addr = base + (32'(beat) * 32'(WORD_BYTES));
  assign host_oor  = ({20'd0, host_addr[13:2]} >= 32'(DEPTH));
  assign host_slot = (state == ST_BURST) && (!CpuReq || force_slot);
  assign last_beat = (beat == (len - 1'b1));
  assign CpuRData  = MemRData;

`ifdef DMEM_ARB_FAIRNESS_EN
  dmem_arb_starve_guard #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_guard (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy       (state == ST_BURST),
    .cpu_req    (CpuReq),
    .host_slot  (host_slot),
    .force_slot (force_slot)
  );
  assign CpuStall = force_slot && CpuReq;
`else
  logic unused_max_wait;
  assign unused_max_wait = |MAX_WAIT;
  assign force_slot      = 1'b0;
  assign CpuStall        = 1'b0;
`endif

  // Memory port mux: host slot overrides CPU; out-of-range host beats issue
  // no access. MemWe is gated by rst_n so nothing is written while in reset.
  always_comb begin
    MemAddr    = CpuAddr;
    MemWData   = CpuWData;
    MemWe      = CpuReq && CpuWe && !force_slot;
    HostWReady = 1'b0;
    if (host_slot) begin
      MemAddr    = host_addr;
      MemWData   = HostWData;
      MemWe      = dir && !host_oor;
      HostWReady = dir && !host_oor;
    end
    if (!rst_n) begin
      MemWe      = 1'b0;
      HostWReady = 1'b0;
    end
  end

  // Burst sequencer: latches the request in IDLE, advances one beat per host slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base       <= '0;
      len        <= '0;
      dir        <= 1'b0;
      beat       <= '0;
      HostRData  <= '0;
      HostRValid <= 1'b0;
      HostDone   <= 1'b0;
      HostErr    <= 1'b0;
      HostBusy   <= 1'b0;
    end else begin
      HostRValid <= 1'b0;
      HostDone   <= 1'b0;
      HostErr    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (HostReq) begin
            base <= HostAddr;
            len  <= HostLen;
            dir  <= HostWe;
            beat <= '0;
            if (HostLen == '0) begin
              HostDone <= 1'b1;
            end else begin
              state    <= ST_BURST;
              HostBusy <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (host_slot) begin
            if (host_oor) begin
              HostDone <= 1'b1;
              HostErr  <= 1'b1;
              HostBusy <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              if (!dir) begin
                HostRData  <= MemRData;
                HostRValid <= 1'b1;
              end
              beat <= beat + 1'b1;
              if (last_beat) begin
                HostDone <= 1'b1;
                HostBusy <= 1'b0;
                state    <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
